// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO on a one-read/one-write storage array with circular
// write and read pointers. Occupancy is tracked by a separate counter, which
// is the only thing that distinguishes full from empty (pointers carry no
// wrap bit). All outputs are registered; flags are derived from the
// next-state count so they always agree with oCount in the same cycle.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 4,
    parameter int ALMOST_FULL_THR  = 12,
    parameter int ALMOST_EMPTY_THR = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iPush,
    input  logic [DATA_WIDTH-1:0] iDataIn,
    input  logic                  iPop,
    output logic [DATA_WIDTH-1:0] oDataOut,
    output logic                  oDataValid,
    output logic [ADDR_WIDTH:0]   oCount,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oAlmostFull,
    output logic                  oAlmostEmpty,
    output logic                  oOverflow,
    output logic                  oUnderflow
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]         COUNT_ONE = CW'(1);
    localparam logic [CW-1:0]         COUNT_ZERO = CW'(0);
    localparam logic [CW-1:0]         AF_THR_C  = CW'(ALMOST_FULL_THR);
    localparam logic [CW-1:0]         AE_THR_C  = CW'(ALMOST_EMPTY_THR);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = ADDR_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

    // Storage array; deliberately never cleared by Reset.
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_r;
    logic [ADDR_WIDTH-1:0] rptr_r;
    logic [CW-1:0]         count_r;

    logic                  pop_ok_s;
    logic                  push_ok_s;
    logic [CW-1:0]         count_nxt_s;
    logic [ADDR_WIDTH-1:0] wptr_nxt_s;
    logic [ADDR_WIDTH-1:0] rptr_nxt_s;

    // Acceptance decisions, taken against the pre-edge occupancy. A push into
    // a full FIFO is accepted only when a pop frees a slot on the same edge;
    // a pop from an empty FIFO is never accepted, so there is no bypass.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (iPop && (count_r != COUNT_ZERO)) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (iPush && ((count_r != DEPTH_C) || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Next-state count: push-only increments, pop-only decrements,
    // simultaneous or idle leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + COUNT_ONE;
            2'b01:   count_nxt_s = count_r - COUNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Next-state pointers; natural ADDR_WIDTH overflow gives the modulo-DEPTH wrap.
    always_comb begin
        wptr_nxt_s = wptr_r;
        rptr_nxt_s = rptr_r;
        if (push_ok_s) begin
            wptr_nxt_s = wptr_r + PTR_ONE;
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (pop_ok_s) begin
            rptr_nxt_s = rptr_r + PTR_ONE;
        end else begin
            rptr_nxt_s = rptr_r;
        end
    end

    // Storage write port; suppressed while Reset is asserted so a reset cycle
    // never leaves a stray word behind the freshly cleared pointers.
    always_ff @(posedge Clock) begin
        if (push_ok_s && !Reset) begin
            mem_r[wptr_r] <= iDataIn;
        end
    end

    // Pointer, count, read-data and status registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wptr_r       <= PTR_ZERO;
            rptr_r       <= PTR_ZERO;
            count_r      <= COUNT_ZERO;
            oCount       <= COUNT_ZERO;
            oDataOut     <= DATA_ZERO;
            oDataValid   <= 1'b0;
            oEmpty       <= 1'b1;
            oFull        <= 1'b0;
            oAlmostFull  <= 1'b0;
            oAlmostEmpty <= 1'b1;
            oOverflow    <= 1'b0;
            oUnderflow   <= 1'b0;
        end else begin
            wptr_r       <= wptr_nxt_s;
            rptr_r       <= rptr_nxt_s;
            count_r      <= count_nxt_s;
            oCount       <= count_nxt_s;
            oEmpty       <= (count_nxt_s == COUNT_ZERO);
            oFull        <= (count_nxt_s == DEPTH_C);
            oAlmostFull  <= (count_nxt_s >= AF_THR_C);
            oAlmostEmpty <= (count_nxt_s <= AE_THR_C);
            oOverflow    <= iPush && !push_ok_s;
            oUnderflow   <= iPop && !pop_ok_s;
            if (pop_ok_s) begin
                oDataOut   <= mem_r[rptr_r];
                oDataValid <= 1'b1;
            end else begin
                oDataOut   <= oDataOut;
                oDataValid <= 1'b0;
            end
        end
    end

endmodule
